instr_seq_ctrl: RTL and testbench
=================================

# instr_seq_ctrl

Fetch/decode/execute sequencer for the 4-bit instruction register. It drives the register's latch, clear and bus-enable controls, handshakes instruction fetches with memory, and decodes the opcode into ALU, accumulator and program-counter strobes. It sits between memory, the instruction register, the ALU/accumulator and the PC.

## Interface
Parameters:
- ACK_TIMEOUT, 15: FETCH cycles without MemAck before bus fault (1..15, 4-bit counter).

Ports:
- MainClock  in  1  system clock; all state changes on the rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Run  in  1  level; 1 = execute continuously, 0 = stop after the current instruction.
- MemAck  in  1  memory has instruction on Instr bus (single-cycle pulse or level).
- ToInstr  in  4  opcode from the instruction register outputs.
- ZeroFlag  in  1  accumulator zero flag.
- MemRead  out  1  instruction fetch request.
- LatchInstrReg  out  1  instruction register capture enable (ANDed with MainClock downstream).
- ClearInstrReg  out  1  active-high instruction register clear.
- EnableInstrReg  out  1  drive the IR data field onto the IB bus.
- PCInc  out  1  increment PC.
- PCLoad  out  1  load PC from IB.
- AccLoad  out  1  accumulator write.
- AluOp  out  3  ALU function.
- Halted  out  1  in HALT.
- IllegalOp  out  1  one-cycle pulse on an undefined opcode.
- BusFault  out  1  one-cycle pulse on a fetch timeout.

## Operation
- The FSM uses one-hot states: IDLE, FETCH, LATCH, DECODE, EXEC, HALT. Every output is a flop or an OR of state flops, so outputs are glitch-free. This is mandatory because LatchInstrReg gates a clock.
- Reset (ResetN=0): state IDLE and timeout counter 0, applied asynchronously. ClearInstrReg=1 while ResetN=0. All other outputs are 0 and AluOp=000.
- IDLE: all outputs 0. Run=1 moves to FETCH.
- FETCH: MemRead=1 and the timeout counter increments each cycle.
  - MemAck=1 moves to LATCH and clears the counter.
  - If the counter reaches ACK_TIMEOUT with no ack, the next cycle is IDLE with BusFault=1 and ClearInstrReg=1 for that one cycle.
  - If MemAck arrives on the same cycle as the timeout, the ack wins.
- LATCH: LatchInstrReg=1 and PCInc=1 for exactly one cycle, then DECODE.
- DECODE: the FSM samples ToInstr into an internal opcode register. Opcode 1111 goes to HALT; any other opcode goes to EXEC.
- EXEC lasts one cycle. Actions by opcode:
  - 0000 NOP: no strobes.
  - 0001 LDI: EnableInstrReg, AccLoad, AluOp=000.
  - 0010 ADD: EnableInstrReg, AccLoad, AluOp=001.
  - 0011 SUB: as ADD with AluOp=010.
  - 0100 AND: as ADD with AluOp=011.
  - 0101 OR: as ADD with AluOp=100.
  - 0110 JMP: EnableInstrReg, PCLoad.
  - 0111 JZ: EnableInstrReg; PCLoad only if ZeroFlag=1 in EXEC.
  - 1000–1110: IllegalOp=1, otherwise behaves as NOP.
- After EXEC: Run=1 goes to FETCH, Run=0 goes to IDLE.
- HALT: Halted=1, held until a 0→1 edge of Run is detected (edge register). That edge gives one cycle with ClearInstrReg=1, then FETCH. A Run level held high across HALT entry does not exit HALT.
- AluOp=000 and EnableInstrReg=0 outside EXEC.
- Run dropping mid-instruction never aborts it; the current instruction completes.

## Timing
- Zero-wait fetch (MemAck in the first FETCH cycle): one instruction takes 4 cycles (FETCH, LATCH, DECODE, EXEC). Each extra wait cycle adds 1.
- The IR captures on the rising edge that ends the LATCH cycle. ToInstr is valid in DECODE.
- The PC increments once per instruction, in LATCH. A taken jump's PCLoad in EXEC overrides the earlier increment.
- Outputs change only after rising MainClock edges. The exception is ClearInstrReg, which asserts immediately on ResetN falling.
- Reset mid-operation: return to IDLE immediately, with no pending strobes after release. The first FETCH comes one cycle after ResetN=1 and Run=1.

## Test plan
- Reset, then Run=1, MemAck=1 every FETCH, opcode 0010 → the sequence MemRead, LatchInstrReg+PCInc, –, EnableInstrReg+AccLoad+AluOp=001 repeats every 4 cycles.
- MemAck withheld with ACK_TIMEOUT=15 → MemRead high for 15 cycles, then BusFault and ClearInstrReg pulse 1 cycle, state IDLE. Ack on cycle 15 → LATCH, no fault.
- Opcode 0111 with ZeroFlag=0 → no PCLoad. With ZeroFlag=1 → PCLoad=1 in EXEC. Opcode 1010 → IllegalOp pulse, no strobes.
- Opcode 1111 with Run held at 1 → Halted stays 1. Run 0→1 → ClearInstrReg 1 cycle, then MemRead.
- Run dropped during LATCH → EXEC completes, then IDLE with all outputs 0.
- ResetN pulsed low during EXEC → ClearInstrReg=1 and all other outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/instr_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 4-bit instruction register.
// One-hot FSM; every output is a flop, an OR of flops, or a documented input gate.
module instr_seq_ctrl #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       MainClock,
    input  logic       ResetN,
    input  logic       Run,
    input  logic       MemAck,
    input  logic [3:0] ToInstr,
    input  logic       ZeroFlag,
    output logic       MemRead,
    output logic       LatchInstrReg,
    output logic       ClearInstrReg,
    output logic       EnableInstrReg,
    output logic       PCInc,
    output logic       PCLoad,
    output logic       AccLoad,
    output logic [2:0] AluOp,
    output logic       Halted,
    output logic       IllegalOp,
    output logic       BusFault
);

    localparam int I_IDLE   = 0;
    localparam int I_FETCH  = 1;
    localparam int I_LATCH  = 2;
    localparam int I_DECODE = 3;
    localparam int I_EXEC   = 4;
    localparam int I_HALT   = 5;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_FETCH  = 6'b000010,
        S_LATCH  = 6'b000100,
        S_DECODE = 6'b001000,
        S_EXEC   = 6'b010000,
        S_HALT   = 6'b100000
    } state_t;

    localparam logic [3:0] TIMEOUT_LAST = 4'(ACK_TIMEOUT - 1);

    state_t     state_reg,   state_next;
    logic [3:0] cnt_reg,     cnt_next;
    logic       run_prev_reg;
    logic       restart_reg, restart_next;
    logic       clear_reg,   clear_next;
    logic       fault_reg,   fault_next;
    // The opcode is captured in DECODE in already-decoded form, so EXEC
    // strobes come straight from flops.
    logic       en_reg,      en_next;
    logic       acc_reg,     acc_next;
    logic [2:0] alu_reg,     alu_next;
    logic       jmp_reg,     jmp_next;
    logic       jz_reg,      jz_next;
    logic       ill_reg,     ill_next;

    always_ff @(posedge MainClock or negedge ResetN) begin
        if (!ResetN) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 4'd0;
            run_prev_reg <= 1'b0;
            restart_reg  <= 1'b0;
            clear_reg    <= 1'b0;
            fault_reg    <= 1'b0;
            en_reg       <= 1'b0;
            acc_reg      <= 1'b0;
            alu_reg      <= 3'd0;
            jmp_reg      <= 1'b0;
            jz_reg       <= 1'b0;
            ill_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            run_prev_reg <= Run;
            restart_reg  <= restart_next;
            clear_reg    <= clear_next;
            fault_reg    <= fault_next;
            en_reg       <= en_next;
            acc_reg      <= acc_next;
            alu_reg      <= alu_next;
            jmp_reg      <= jmp_next;
            jz_reg       <= jz_next;
            ill_reg      <= ill_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        restart_next = 1'b0;
        clear_next   = 1'b0;
        fault_next   = 1'b0;
        en_next      = 1'b0;
        acc_next     = 1'b0;
        alu_next     = 3'd0;
        jmp_next     = 1'b0;
        jz_next      = 1'b0;
        ill_next     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (restart_reg || Run) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (MemAck) begin
                    state_next = S_LATCH;
                    cnt_next   = 4'd0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = S_IDLE;
                    cnt_next   = 4'd0;
                    fault_next = 1'b1;
                    clear_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_LATCH: state_next = S_DECODE;
            S_DECODE: begin
                state_next = S_EXEC;
                case (ToInstr)
                    4'h0: ;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                        en_next  = 1'b1;
                        acc_next = 1'b1;
                        alu_next = 3'(ToInstr - 4'd1);
                    end
                    4'h6: begin
                        en_next  = 1'b1;
                        jmp_next = 1'b1;
                    end
                    4'h7: begin
                        en_next = 1'b1;
                        jz_next = 1'b1;
                    end
                    4'hF: state_next = S_HALT;
                    default: ill_next = 1'b1;
                endcase
            end
            S_EXEC: state_next = Run ? S_FETCH : S_IDLE;
            S_HALT: begin
                // Only a fresh rising edge of Run restarts; a held level does not.
                if (Run && !run_prev_reg) begin
                    state_next   = S_IDLE;
                    restart_next = 1'b1;
                    clear_next   = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign MemRead        = state_reg[I_FETCH];
    assign LatchInstrReg  = state_reg[I_LATCH];
    assign PCInc          = state_reg[I_LATCH];
    assign Halted         = state_reg[I_HALT];
    assign ClearInstrReg  = clear_reg | ~ResetN;
    assign BusFault       = fault_reg;
    assign EnableInstrReg = en_reg;
    assign AccLoad        = acc_reg;
    assign AluOp          = alu_reg;
    assign IllegalOp      = ill_reg;
    // JZ must see ZeroFlag during EXEC itself, so this one strobe gates an input.
    assign PCLoad         = jmp_reg | (jz_reg & ZeroFlag);

    logic unused_idx;
    assign unused_idx = state_reg[I_IDLE] ^ state_reg[I_DECODE] ^ state_reg[I_EXEC];

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed bench for instr_seq_ctrl: instruction-level expected trace plus literal pins.
module tb_instr_seq_ctrl;

    logic       MainClock = 1'b0;
    logic       ResetN    = 1'b0;
    logic       Run       = 1'b0;
    logic       MemAck    = 1'b0;
    logic       ZeroFlag  = 1'b0;
    logic [3:0] ToInstr   = 4'h0;
    logic       MemRead, LatchInstrReg, ClearInstrReg, EnableInstrReg;
    logic       PCInc, PCLoad, AccLoad, Halted, IllegalOp, BusFault;
    logic [2:0] AluOp;

    always #5 MainClock = ~MainClock;

    instr_seq_ctrl #(.ACK_TIMEOUT(15)) dut (
        .MainClock(MainClock), .ResetN(ResetN), .Run(Run), .MemAck(MemAck),
        .ToInstr(ToInstr), .ZeroFlag(ZeroFlag), .MemRead(MemRead),
        .LatchInstrReg(LatchInstrReg), .ClearInstrReg(ClearInstrReg),
        .EnableInstrReg(EnableInstrReg), .PCInc(PCInc), .PCLoad(PCLoad),
        .AccLoad(AccLoad), .AluOp(AluOp), .Halted(Halted),
        .IllegalOp(IllegalOp), .BusFault(BusFault)
    );

    // Output vector: MR LI CL EN PI PL AL AluOp[2:0] HA IL BF
    localparam logic [12:0] V_MR    = 13'h1000;
    localparam logic [12:0] V_LATCH = 13'h0900;
    localparam logic [12:0] V_CL    = 13'h0400;
    localparam logic [12:0] V_EN    = 13'h0200;
    localparam logic [12:0] V_PL    = 13'h0080;
    localparam logic [12:0] V_AL    = 13'h0040;
    localparam logic [12:0] V_HA    = 13'h0004;
    localparam logic [12:0] V_IL    = 13'h0002;
    localparam logic [12:0] V_BF    = 13'h0001;

    logic [12:0] obs;
    assign obs = {MemRead, LatchInstrReg, ClearInstrReg, EnableInstrReg, PCInc,
                  PCLoad, AccLoad, AluOp, Halted, IllegalOp, BusFault};

    int tests = 0;
    int fails = 0;
    logic [12:0] exp_q[$];
    string       tag_q[$];

    // EXEC-cycle outputs from the opcode table.
    function automatic logic [12:0] exec_vec(input logic [3:0] op, input logic zero);
        logic [3:0] fn;
        fn = op - 4'd1;
        case (op)
            4'h0:                         return 13'h0;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: return V_EN | V_AL | (13'(fn[2:0]) << 3);
            4'h6:                         return V_EN | V_PL;
            4'h7:                         return zero ? (V_EN | V_PL) : V_EN;
            default:                      return V_IL;
        endcase
    endfunction

    always @(negedge MainClock) begin
        logic [12:0] e;
        string       t;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL %s: outputs=%h required=%h", t, obs, e);
            end
        end
    end

    task automatic lit(input string t, input logic [12:0] a, input logic [12:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got=%h required=%h", t, a, e);
        end
    endtask

    task automatic cyc(input logic run, input logic ack, input logic zero,
                       input logic [12:0] e, input string t);
        @(negedge MainClock);
        Run = run;
        MemAck = ack;
        ZeroFlag = zero;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // One instruction starting in FETCH; HALT opcode stops after DECODE.
    task automatic instr(input int waits, input logic [3:0] op, input logic zero,
                         input logic run_early, input logic run_late, input string t);
        for (int i = 0; i < waits; i++) cyc(run_early, 1'b0, zero, V_MR, {t, "/fetch"});
        cyc(run_early, 1'b1, zero, V_MR, {t, "/fetch_ack"});
        ToInstr = op;
        cyc(run_late, 1'b0, zero, V_LATCH, {t, "/latch"});
        cyc(run_late, 1'b0, zero, 13'h0, {t, "/decode"});
        if (op != 4'hF) cyc(run_late, 1'b0, zero, exec_vec(op, zero), {t, "/exec"});
        $display("[TB] instr %s op=%h waits=%0d zero=%0d", t, op, waits, zero);
    endtask

    initial begin
        repeat (3) @(negedge MainClock);
        lit("reset_state", obs, 13'h0400);
        @(negedge MainClock);
        ResetN = 1'b1;

        // Back-to-back ADD with zero-wait fetches.
        cyc(1'b1, 1'b0, 1'b0, 13'h0, "add/idle");
        instr(0, 4'h2, 1'b0, 1'b1, 1'b1, "add0");
        instr(0, 4'h2, 1'b0, 1'b1, 1'b1, "add1");
        instr(0, 4'h2, 1'b0, 1'b1, 1'b0, "add2");
        #3 lit("add_exec_lit", obs, 13'h0248);
        cyc(1'b0, 1'b0, 1'b0, 13'h0, "add/idle_after");

        // Fetch timeout: 15 MemRead cycles, then one fault cycle in IDLE.
        cyc(1'b1, 1'b0, 1'b0, 13'h0, "tmo/idle");
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, V_MR, "tmo/fetch");
        cyc(1'b0, 1'b0, 1'b0, V_BF | V_CL, "tmo/fault");
        #3 lit("tmo_fault_lit", obs, 13'h0401);
        cyc(1'b0, 1'b0, 1'b0, 13'h0, "tmo/idle_after");
        $display("[TB] timeout sequence done");

        // Ack on the 15th FETCH cycle wins over the timeout.
        cyc(1'b1, 1'b0, 1'b0, 13'h0, "ack15/idle");
        instr(14, 4'h1, 1'b0, 1'b0, 1'b0, "ack15");
        cyc(1'b0, 1'b0, 1'b0, 13'h0, "ack15/idle_after");

        // Branches, logic ops, NOP and an undefined opcode.
        cyc(1'b1, 1'b0, 1'b0, 13'h0, "mix/idle");
        instr(0, 4'h7, 1'b0, 1'b1, 1'b1, "jz_nz");
        instr(2, 4'h7, 1'b1, 1'b1, 1'b1, "jz_z");
        #3 lit("jz_taken_lit", obs, 13'h0280);
        instr(0, 4'h6, 1'b0, 1'b1, 1'b1, "jmp");
        instr(1, 4'h3, 1'b0, 1'b1, 1'b1, "sub");
        instr(0, 4'h4, 1'b1, 1'b1, 1'b1, "and");
        instr(0, 4'h5, 1'b0, 1'b1, 1'b1, "or");
        instr(0, 4'h0, 1'b0, 1'b1, 1'b1, "nop");
        instr(0, 4'hA, 1'b0, 1'b1, 1'b0, "ill");
        #3 lit("illegal_lit", obs, 13'h0002);
        cyc(1'b0, 1'b0, 1'b0, 13'h0, "mix/idle_after");

        // HALT with Run held high, then a fresh rising edge restarts.
        cyc(1'b1, 1'b0, 1'b0, 13'h0, "hlt/idle");
        instr(0, 4'hF, 1'b0, 1'b1, 1'b1, "hlt");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, V_HA, "hlt/held");
        #3 lit("halted_lit", obs, 13'h0004);
        cyc(1'b0, 1'b0, 1'b0, V_HA, "hlt/run_low");
        cyc(1'b1, 1'b0, 1'b0, V_HA, "hlt/run_rise");
        cyc(1'b0, 1'b0, 1'b0, V_CL, "hlt/restart_clear");
        instr(0, 4'h0, 1'b0, 1'b0, 1'b0, "post_hlt");
        cyc(1'b0, 1'b0, 1'b0, 13'h0, "hlt/idle_after");

        // Run dropped during LATCH: instruction completes, then IDLE.
        cyc(1'b1, 1'b0, 1'b0, 13'h0, "drop/idle");
        instr(0, 4'h2, 1'b0, 1'b1, 1'b0, "drop");
        cyc(1'b1, 1'b0, 1'b0, 13'h0, "drop/idle_after");
        cyc(1'b0, 1'b0, 1'b0, V_MR, "drop/refetch");
        cyc(1'b0, 1'b1, 1'b0, V_MR, "drop/refetch_ack");
        ToInstr = 4'h0;
        cyc(1'b0, 1'b0, 1'b0, V_LATCH, "drop/latch");
        cyc(1'b0, 1'b0, 1'b0, 13'h0, "drop/decode");
        cyc(1'b0, 1'b0, 1'b0, 13'h0, "drop/exec_nop");
        cyc(1'b0, 1'b0, 1'b0, 13'h0, "drop/idle_end");

        // Asynchronous reset in the middle of EXEC.
        cyc(1'b1, 1'b0, 1'b0, 13'h0, "rst/idle");
        cyc(1'b1, 1'b1, 1'b0, V_MR, "rst/fetch");
        ToInstr = 4'h2;
        cyc(1'b1, 1'b0, 1'b0, V_LATCH, "rst/latch");
        cyc(1'b1, 1'b0, 1'b0, 13'h0, "rst/decode");
        cyc(1'b1, 1'b0, 1'b0, exec_vec(4'h2, 1'b0), "rst/exec");
        #3 ResetN = 1'b0;
        #1 lit("rst_async_lit", obs, 13'h0400);
        @(negedge MainClock);
        #1 lit("rst_held_lit", obs, 13'h0400);
        cyc(1'b1, 1'b0, 1'b0, 13'h0, "rst/release");
        ResetN = 1'b1;
        instr(0, 4'h1, 1'b0, 1'b1, 1'b0, "post_rst");
        cyc(1'b0, 1'b0, 1'b0, 13'h0, "rst/idle_after");

        repeat (2) @(negedge MainClock);
        #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
